uart_receiver: RTL and testbench

UART_RECEIVER -- requirements
Module: uart_receiver

---
 rtl/uart_pkg.sv | 26 ++
 rtl/uart_baud_tick.sv | 39 +++
 rtl/uart_receiver.sv | 164 ++++++++++++++++
 tb/tb_uart_receiver.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// -----------------------------------------------------------------------------
// uart_pkg
//   Shared definitions for the 8N1 UART receiver: FSM state encoding,
//   oversampling ratio, data width and the tick indices at which the start,
//   data and stop bits are sampled.
// -----------------------------------------------------------------------------
package uart_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } uart_state_t;

  localparam int OVERSAMPLE = 16;
  localparam int DATA_BITS  = 8;

  // Start bit is checked halfway through (8th tick), data bits and the stop
  // bit on the last tick of each 16-tick bit period.
  localparam logic [3:0] START_SAMPLE_TICK = 4'd7;
  localparam logic [3:0] BIT_SAMPLE_TICK   = 4'(OVERSAMPLE - 1);
  localparam logic [3:0] STOP_SAMPLE_TICK  = 4'd15;
  localparam logic [2:0] LAST_BIT_IDX      = 3'(DATA_BITS - 1);

endpackage

// File: rtl/uart_baud_tick.sv
// -----------------------------------------------------------------------------
// uart_baud_tick
//   Free-running divider producing a one-cycle tick every CLKS_PER_TICK
//   sysclk cycles (16x oversample rate). restart realigns the divider to a
//   detected start edge.
//
// Ports
//   sysclk  : system clock, rising edge
//   reset   : synchronous, active-high
//   restart : clears the divider this cycle
//   tick    : high for one cycle when the divider reaches its terminal count
// -----------------------------------------------------------------------------
module uart_baud_tick #(
  parameter int unsigned CLKS_PER_TICK = 325
) (
  input  logic sysclk,
  input  logic reset,
  input  logic restart,
  output logic tick
);

  localparam logic [15:0] LAST_CNT = 16'(CLKS_PER_TICK - 1);

  logic [15:0] cnt;

  always_ff @(posedge sysclk) begin
    if (reset || restart) begin
      cnt <= '0;
    end else if (cnt == LAST_CNT) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 16'd1;
    end
  end

  // With CLKS_PER_TICK = 1 the terminal count is 0, so tick is held high.
  assign tick = (cnt == LAST_CNT);

endmodule

// File: rtl/uart_receiver.sv
// -----------------------------------------------------------------------------
// uart_receiver
//   8N1 UART receiver with 16x oversampling. The serial line is
//   synchronised, a falling edge in IDLE starts a frame, the start bit is
//   re-checked mid-bit, eight data bits are shifted in LSB first and the stop
//   bit decides between a good byte (RX_STATUS) and a framing error (RX_FERR).
//
// Ports
//   sysclk    : system clock, rising edge
//   reset     : synchronous, active-high
//   UART_RX   : asynchronous serial input, idle high
//   RX_DATA   : last correctly framed byte, held until the next good frame
//   RX_STATUS : one-cycle pulse, RX_DATA updated
//   RX_FERR   : one-cycle pulse, frame ended with a low stop bit
//   state_dbg : current FSM state, for observation only
//
// Handshake: RX_STATUS and RX_FERR are single-cycle strobes with no ready;
// the consumer must sample RX_DATA on the RX_STATUS cycle or later (it holds).
// -----------------------------------------------------------------------------
module uart_receiver
  import uart_pkg::*;
#(
  parameter int unsigned CLKS_PER_TICK = 325
) (
  input  logic        sysclk,
  input  logic        reset,
  input  logic        UART_RX,
  output logic [7:0]  RX_DATA,
  output logic        RX_STATUS,
  output logic        RX_FERR,
  output uart_state_t state_dbg
);

  // Synchroniser plus one more stage for falling-edge detection.
  logic rx_meta;
  logic rx_s;
  logic rx_d;

  uart_state_t state, state_n;
  logic [3:0]  tick_cnt, tick_cnt_n;
  logic [2:0]  bit_idx, bit_idx_n;
  logic [7:0]  shreg, shreg_n;
  logic [7:0]  rx_data_n;
  logic        status_n;
  logic        ferr_n;
  logic        start_edge;
  logic        tick;

  uart_baud_tick #(
    .CLKS_PER_TICK (CLKS_PER_TICK)
  ) u_baud_tick (
    .sysclk  (sysclk),
    .reset   (reset),
    .restart (start_edge),
    .tick    (tick)
  );

  always_ff @(posedge sysclk) begin
    if (reset) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
      rx_d    <= 1'b1;
    end else begin
      rx_meta <= UART_RX;
      rx_s    <= rx_meta;
      rx_d    <= rx_s;
    end
  end

  always_ff @(posedge sysclk) begin
    if (reset) begin
      state     <= ST_IDLE;
      tick_cnt  <= '0;
      bit_idx   <= '0;
      shreg     <= '0;
      RX_DATA   <= '0;
      RX_STATUS <= 1'b0;
      RX_FERR   <= 1'b0;
    end else begin
      state     <= state_n;
      tick_cnt  <= tick_cnt_n;
      bit_idx   <= bit_idx_n;
      shreg     <= shreg_n;
      RX_DATA   <= rx_data_n;
      RX_STATUS <= status_n;
      RX_FERR   <= ferr_n;
    end
  end

  always_comb begin
    state_n    = state;
    tick_cnt_n = tick_cnt;
    bit_idx_n  = bit_idx;
    shreg_n    = shreg;
    rx_data_n  = RX_DATA;
    status_n   = 1'b0;
    ferr_n     = 1'b0;
    start_edge = 1'b0;

    unique case (state)
      ST_IDLE: begin
        // A line that is already low (break) gives no edge, so the receiver
        // waits here until the line has been high again.
        if (rx_d && !rx_s) begin
          start_edge = 1'b1;
          state_n    = ST_START;
          tick_cnt_n = '0;
        end
      end

      ST_START: begin
        if (tick) begin
          if (tick_cnt == START_SAMPLE_TICK) begin
            tick_cnt_n = '0;
            bit_idx_n  = '0;
            // High at mid start bit is treated as a glitch.
            state_n    = rx_s ? ST_IDLE : ST_DATA;
          end else begin
            tick_cnt_n = tick_cnt + 4'd1;
          end
        end
      end

      ST_DATA: begin
        if (tick) begin
          // Modulo-16 counter: wraps to 0 on the sampling tick.
          tick_cnt_n = tick_cnt + 4'd1;
          if (tick_cnt == BIT_SAMPLE_TICK) begin
            shreg_n[bit_idx] = rx_s;
            // bit_idx wraps 7->0 exactly as the FSM leaves DATA.
            bit_idx_n = bit_idx + 3'd1;
            if (bit_idx == LAST_BIT_IDX) begin
              state_n = ST_STOP;
            end
          end
        end
      end

      ST_STOP: begin
        if (tick) begin
          if (tick_cnt == STOP_SAMPLE_TICK) begin
            tick_cnt_n = '0;
            state_n    = ST_IDLE;
            if (rx_s) begin
              rx_data_n = shreg;
              status_n  = 1'b1;
            end else begin
              ferr_n = 1'b1;
            end
          end else begin
            tick_cnt_n = tick_cnt + 4'd1;
          end
        end
      end

      default: begin
        state_n = ST_IDLE;
      end
    endcase
  end

  assign state_dbg = state;

endmodule

// File: tb/tb_uart_receiver.sv
// -----------------------------------------------------------------------------
// tb_uart_receiver
//   Directed and randomised 8N1 frames at 16 sysclk per bit. Expected bytes
//   and framing errors come from a frame-level model: a frame with a high
//   stop bit delivers its byte, a low stop bit gives a framing error and
//   leaves the last good byte in place.
// -----------------------------------------------------------------------------
module tb_uart_receiver;
  import uart_pkg::*;

  localparam int BIT_CYCLES = 16;

  logic        sysclk;
  logic        reset;
  logic        UART_RX;
  logic [7:0]  RX_DATA;
  logic        RX_STATUS;
  logic        RX_FERR;
  uart_state_t state_dbg;

  uart_receiver #(
    .CLKS_PER_TICK (1)
  ) dut (
    .sysclk    (sysclk),
    .reset     (reset),
    .UART_RX   (UART_RX),
    .RX_DATA   (RX_DATA),
    .RX_STATUS (RX_STATUS),
    .RX_FERR   (RX_FERR),
    .state_dbg (state_dbg)
  );

  // ---------------- clock / reset ----------------
  initial sysclk = 1'b0;
  always #5 sysclk = ~sysclk;

  int cyc = 0;
  always @(posedge sysclk) cyc <= cyc + 1;

  // ---------------- scoreboard ----------------
  // Entry: {is_ferr, data}; framing errors carry data 8'h00.
  logic [8:0] exp_q[$];
  logic [8:0] obs_q[$];
  int         obs_cyc[$];
  logic [7:0] last_good;
  int         vectors = 0;
  int         miscompares = 0;

  always @(negedge sysclk) begin
    if (RX_STATUS) begin
      obs_q.push_back({1'b0, RX_DATA});
      obs_cyc.push_back(cyc);
    end
    if (RX_FERR) begin
      obs_q.push_back({1'b1, 8'h00});
      obs_cyc.push_back(cyc);
    end
  end

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Frame-level reference model.
  task automatic model_frame(input logic [7:0] d, input logic stop);
    if (stop) begin
      exp_q.push_back({1'b0, d});
      last_good = d;
    end else begin
      exp_q.push_back({1'b1, 8'h00});
    end
  endtask

  task automatic check_events(input string tag);
    int n;
    check({tag, "_count"}, 16'(obs_q.size()), 16'(exp_q.size()));
    n = (obs_q.size() < exp_q.size()) ? obs_q.size() : exp_q.size();
    for (int i = 0; i < n; i++) begin
      check($sformatf("%s_ev%0d", tag, i), 16'(obs_q[i]), 16'(exp_q[i]));
    end
    check({tag, "_rx_data"}, 16'(RX_DATA), 16'(last_good));
    obs_q.delete();
    exp_q.delete();
    obs_cyc.delete();
  endtask

  // ---------------- drivers ----------------
  task automatic drive_bit(input logic b);
    UART_RX = b;
    repeat (BIT_CYCLES) @(negedge sysclk);
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stop);
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(d[i]);
    drive_bit(stop);
  endtask

  task automatic idle(input int n);
    UART_RX = 1'b1;
    repeat (n) @(negedge sysclk);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [7:0] d;
    logic       stop;
    int         spacing;

    last_good = 8'h00;
    reset     = 1'b1;
    UART_RX   = 1'b1;
    repeat (3) @(negedge sysclk);
    check("rst_rx_data", 16'(RX_DATA), 16'h0000);
    check("rst_status", 16'(RX_STATUS), 16'h0000);
    check("rst_ferr", 16'(RX_FERR), 16'h0000);
    check("rst_state", 16'(state_dbg), 16'(ST_IDLE));
    reset = 1'b0;
    idle(8);

    // Single good frame.
    send_frame(8'h35, 1'b1);
    model_frame(8'h35, 1'b1);
    idle(20);
    check_events("single_35");

    // Back-to-back frames, no idle gap.
    send_frame(8'h35, 1'b1);
    model_frame(8'h35, 1'b1);
    send_frame(8'h23, 1'b1);
    model_frame(8'h23, 1'b1);
    idle(20);
    spacing = (obs_cyc.size() >= 2) ? (obs_cyc[1] - obs_cyc[0]) : -1;
    check("b2b_spacing", 16'(spacing), 16'd160);
    check_events("b2b");

    // Short low glitch, then a real frame.
    UART_RX = 1'b0;
    repeat (4) @(negedge sysclk);
    idle(40);
    check("glitch_state", 16'(state_dbg), 16'(ST_IDLE));
    send_frame(8'hA5, 1'b1);
    model_frame(8'hA5, 1'b1);
    idle(20);
    check_events("glitch_a5");

    // Good byte, then a frame with a low stop bit.
    send_frame(8'h35, 1'b1);
    model_frame(8'h35, 1'b1);
    idle(10);
    send_frame(8'h5A, 1'b0);
    model_frame(8'h5A, 1'b0);
    idle(20);
    check_events("ferr_5a");

    // Reset in the middle of data bit 3; transmitter also abandons the frame.
    d = 8'($urandom_range(0, 255));
    drive_bit(1'b0);
    for (int i = 0; i < 3; i++) drive_bit(d[i]);
    UART_RX = d[3];
    repeat (8) @(negedge sysclk);
    reset   = 1'b1;
    UART_RX = 1'b1;
    @(negedge sysclk);
    last_good = 8'h00;
    check("midrst_rx_data", 16'(RX_DATA), 16'h0000);
    check("midrst_status", 16'(RX_STATUS), 16'h0000);
    check("midrst_ferr", 16'(RX_FERR), 16'h0000);
    check("midrst_state", 16'(state_dbg), 16'(ST_IDLE));
    @(negedge sysclk);
    reset = 1'b0;
    idle(200);
    check_events("midrst_quiet");
    send_frame(8'hFF, 1'b1);
    model_frame(8'hFF, 1'b1);
    idle(20);
    check_events("midrst_ff");

    // Break: line low for 20 bit times, then a 0x00 frame.
    UART_RX = 1'b0;
    repeat (20 * BIT_CYCLES) @(negedge sysclk);
    model_frame(8'h00, 1'b0);
    check("break_state", 16'(state_dbg), 16'(ST_IDLE));
    idle(32);
    send_frame(8'h00, 1'b1);
    model_frame(8'h00, 1'b1);
    idle(20);
    check_events("break_00");

    // Randomised frames with random stop bits and idle gaps.
    for (int f = 0; f < 12; f++) begin
      d    = 8'($urandom_range(0, 255));
      stop = ($urandom_range(0, 3) != 0);
      send_frame(d, stop);
      model_frame(d, stop);
      // After a bad stop the line must go high again before a new start edge.
      idle(stop ? $urandom_range(0, 20) : $urandom_range(16, 30));
    end
    idle(30);
    check_events("random");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
